// File: rtl/vseven_seg_pkg.sv
// Shared constants and types for the seven-segment scanner: segment decode
// table, blank pattern, digit count and the prescaler width helper.
package vseven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a patterns, indexed by nibble (entry 0 is the LSB slice).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    function automatic int pcnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vhex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module vhex_to_seg
    import vseven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/vseven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with a double-buffered
// value that is applied only at frame boundaries.
module vseven_seg_scanner
    import vseven_seg_pkg::*;
#(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        pending,
    output logic        frame_sync
);

    localparam int             PW   = pcnt_width(PRESCALE);
    localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_dig;
    disp_t         r_shadow;
    disp_t         r_active;
    logic          r_pending;
    logic          r_frame_sync;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp_n;

    logic          w_tick;
    logic          w_frame_start;
    disp_t         w_in;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg;
    logic          w_blank_sel;

    assign w_tick        = (r_pcnt == PMAX);
    assign w_frame_start = w_tick && (r_dig == 2'd3);
    assign w_in          = '{value: value, dp: dp, blank: blank};
    assign w_nibble      = r_active.value[{r_dig, 2'b00} +: 4];
    assign w_blank_sel   = r_active.blank[r_dig];

    vhex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt       <= '0;
            r_dig        <= 2'd3;
            r_shadow     <= '0;
            r_active     <= '{value: 16'h0000, dp: 4'h0, blank: 4'hF};
            r_pending    <= 1'b0;
            r_frame_sync <= 1'b0;
            r_an         <= 4'hF;
            r_seg        <= SEG_BLANK;
            r_dp_n       <= 1'b1;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                r_dig <= r_dig + 2'd1;
            end

            if (load) begin
                r_shadow <= w_in;
            end

            // A load coinciding with frame start bypasses the shadow so it is never left pending.
            if (w_frame_start) begin
                if (load) begin
                    r_active <= w_in;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            r_frame_sync <= w_frame_start;

            r_an   <= w_blank_sel ? 4'hF : ~(4'b0001 << r_dig);
            r_seg  <= w_blank_sel ? SEG_BLANK : w_seg;
            r_dp_n <= w_blank_sel | ~r_active.dp[r_dig];
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp_n       = r_dp_n;
    assign pending    = r_pending;
    assign frame_sync = r_frame_sync;

endmodule

// File: tb/tb_vseven_seg_scanner.sv
// Scoreboard bench for vseven_seg_scanner with PRESCALE=4.
module tb_vseven_seg_scanner;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        pending;
    logic        frame_sync;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    vseven_seg_scanner #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .pending    (pending),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl);
        exp_t       e;
        logic [3:0] oh;
        for (int d = 0; d < 4; d++) begin
            oh = 4'b0001 << d;
            if (bl[d]) begin
                e.an   = 4'hF;
                e.seg  = 7'h7F;
                e.dp_n = 1'b1;
            end else begin
                e.an   = ~oh;
                e.seg  = hexseg(v[4*d +: 4]);
                e.dp_n = ~dpv[d];
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl);
        value = v;
        dp    = dpv;
        blank = bl;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_sync(input string tag);
        for (int i = 0; i < 40 && !frame_sync; i++) @(negedge clk);
        check_val({tag, "_sync"}, frame_sync, 1);
    endtask

    // Slot d is visible from 1+4d to 4+4d cycles after frame_sync; sample its first cycle.
    task automatic check_frame(input string tag);
        exp_t e;
        wait_sync(tag);
        check_val({tag, "_pend_at_sync"}, pending, 0);
        for (int d = 0; d < 4; d++) begin
            if (d == 0) @(negedge clk);
            else repeat (P) @(negedge clk);
            e = '0;
            if (sb_q.size() != 0) e = sb_q.pop_front();
            check_val($sformatf("%s_an%0d", tag, d), an, e.an);
            check_val($sformatf("%s_seg%0d", tag, d), seg, e.seg);
            check_val($sformatf("%s_dpn%0d", tag, d), dp_n, e.dp_n);
        end
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        dp    = '0;
        blank = '0;
        repeat (3) @(negedge clk);
        check_val("rst_an", an, 4'hF);
        check_val("rst_seg", seg, 7'h7F);
        check_val("rst_dpn", dp_n, 1);
        check_val("rst_pend", pending, 0);
        check_val("rst_fsync", frame_sync, 0);
        rst_n = 1'b1;

        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (frame_sync) begin
                c = i;
                break;
            end
        end
        check_val("first_sync_cycle", 16'(c), 16'd4);
        check_val("dark_after_rst", an, 4'hF);

        do_load(16'h1234, 4'h0, 4'h0);
        check_val("basic_pend", pending, 1);
        push_frame(16'h1234, 4'h0, 4'h0);
        check_frame("basic");

        do_load(16'hAAAA, 4'h0, 4'h0);
        do_load(16'h5555, 4'h0, 4'h0);
        check_val("ovw_pend", pending, 1);
        push_frame(16'h5555, 4'h0, 4'h0);
        check_frame("ovw");

        repeat (2) @(negedge clk);
        do_load(16'hF00D, 4'h0, 4'h0);
        check_val("coin_fsync", frame_sync, 1);
        check_val("coin_pend", pending, 0);
        push_frame(16'hF00D, 4'h0, 4'h0);
        check_frame("coin");

        do_load(16'h9876, 4'b0001, 4'b0100);
        check_val("blk_pend", pending, 1);
        push_frame(16'h9876, 4'b0001, 4'b0100);
        check_frame("blk");

        do_load(16'h4321, 4'h0, 4'h0);
        push_frame(16'h4321, 4'h0, 4'h0);
        check_frame("pre_rst");

        wait_sync("mid");
        do_load(16'h8888, 4'hF, 4'h0);
        repeat (8) @(negedge clk);
        check_val("mid_an_dig2", an, 4'hB);
        check_val("mid_pend", pending, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_an", an, 4'hF);
        check_val("mid_rst_seg", seg, 7'h7F);
        check_val("mid_rst_dpn", dp_n, 1);
        check_val("mid_rst_pend", pending, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0000, 4'h0, 4'hF);
        check_frame("post_rst");

        check_val("sb_drain", 16'(sb_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
